// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requester-side control and the round-robin arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface rr_grant_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
);
    logic [NUM_REQ-1:0] req_i;
    logic               done_i;
    logic [NUM_REQ-1:0] grant_o;
    logic [IDX_W-1:0]   grant_idx_o;
    logic               grant_valid_o;
    logic               timeout_o;

    modport master (
        output req_i,
        output done_i,
        input  grant_o,
        input  grant_idx_o,
        input  grant_valid_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output grant_o,
        output grant_idx_o,
        output grant_valid_o,
        output timeout_o
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot/binary grant, owner release,
// optional hold timeout, and priority rotation past the last owner.
module rr_grant_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rr_grant_arbiter_if.slave     arb
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]    NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic                grant_valid_q, grant_valid_d;
    logic                timeout_q, timeout_d;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_off;
    logic [IDX_W:0]       pick_sum;
    logic [IDX_W-1:0]     pick_idx;

    logic                 owner_req;
    logic                 hold_expired;
    logic                 release_now;
    logic [IDX_W-1:0]     ptr_next;

    // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        req_dbl    = {arb.req_i, arb.req_i} >> ptr_q;
        req_rot    = req_dbl[NUM_REQ-1:0];
        pick_found = 1'b0;
        pick_off   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_rot[IDX_W'(k)]) begin
                pick_found = 1'b1;
                pick_off   = IDX_W'(k);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
        if (pick_sum >= NUM_REQ_W) begin
            pick_sum = pick_sum - NUM_REQ_W;
        end
        pick_idx = pick_sum[IDX_W-1:0];
    end

    always_comb begin
        owner_req    = arb.req_i[grant_idx_q];
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        release_now  = arb.done_i || !owner_req || hold_expired;
        ptr_next     = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d       = ST_BUSY;
                    grant_idx_d   = pick_idx;
                    grant_d       = NUM_REQ'(1) << pick_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    ptr_d         = ptr_next;
                    // A timeout coinciding with any other release cause is an ordinary release.
                    timeout_d     = hold_expired && !arb.done_i && owner_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign arb.grant_o       = grant_q;
    assign arb.grant_idx_o   = grant_idx_q;
    assign arb.grant_valid_o = grant_valid_q;
    assign arb.timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed scenarios then random traffic,
// each cycle's expected outputs come from a cycle-count reference model.
module tb_rr_grant_arbiter;

    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int HOLD = 15;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [IW-1:0] idx;
        logic          valid;
        logic          tout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_grant_arbiter_if #(.NUM_REQ(N), .IDX_W(IW)) bus ();

    rr_grant_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (IW),
        .MAX_HOLD(HOLD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .arb  (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: who owns the resource, how many cycles it has held it,
    // and where the next search starts.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tout  = 0;

    task automatic model_step(input bit r, input logic [N-1:0] req, input bit done);
        bit withdrew, expired;
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_tout = 0;
            return;
        end
        m_tout = 0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!m_busy && ((req >> c) & 4'b0001) != 0) begin
                    m_busy  = 1;
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else begin
            withdrew = ((req >> m_owner) & 4'b0001) == 0;
            expired  = (HOLD != 0) && (m_held == HOLD);
            if (done || withdrew || expired) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
                m_tout = expired && !done && !withdrew;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic drive(input bit r, input logic [N-1:0] req, input bit done);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.req_i  = req;
        bus.done_i = done;
        model_step(r, req, done);
        e.grant = m_busy ? N'(1 << m_owner) : '0;
        e.idx   = IW'(m_owner);
        e.valid = m_busy;
        e.tout  = m_tout;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
    endtask

    // Monitor: compares the DUT after each edge against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant_o",       int'(bus.grant_o),       int'(e.grant));
            check("grant_idx_o",   int'(bus.grant_idx_o),   int'(e.idx));
            check("grant_valid_o", int'(bus.grant_valid_o), int'(e.valid));
            check("timeout_o",     int'(bus.timeout_o),     int'(e.tout));
        end
    end

    initial begin
        bus.req_i  = '0;
        bus.done_i = 1'b0;

        // Reset with all requesting, then first grant goes to requester 0.
        drive(1, 4'b1111, 0);
        drive(1, 4'b1111, 0);
        // Rotation with done one cycle after each grant.
        repeat (5) begin
            drive(0, 4'b1111, 0);
            drive(0, 4'b1111, 1);
        end
        // Walk ptr to 3 then apply sparse requests to exercise skip and wrap.
        drive(0, 4'b0100, 0);
        drive(0, 4'b0100, 1);
        repeat (2) begin
            drive(0, 4'b0101, 0);
            drive(0, 4'b0101, 1);
        end
        // Timeout with a single held request, then regrant.
        repeat (20) drive(0, 4'b0010, 0);
        drive(0, 4'b0000, 0);
        drive(0, 4'b0000, 0);
        // Owner withdraws mid-grant.
        drive(0, 4'b1000, 0);
        drive(0, 4'b1000, 0);
        drive(0, 4'b0000, 0);
        drive(0, 4'b0000, 0);
        // done on the timeout cycle.
        repeat (HOLD) drive(0, 4'b0001, 0);
        drive(0, 4'b0001, 1);
        drive(0, 4'b0000, 0);
        // done while idle.
        drive(0, 4'b0000, 1);
        drive(0, 4'b0000, 1);
        // Reset while granting requester 2.
        drive(0, 4'b0100, 0);
        drive(0, 4'b0100, 0);
        drive(1, 4'b1100, 0);
        drive(0, 4'b1100, 0);
        drive(0, 4'b1100, 1);
        drive(0, 4'b0000, 0);

        // Random traffic: sticky requests so timeouts can occur.
        begin
            logic [N-1:0] req;
            req = N'($urandom);
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7) == 0) req = N'($urandom);
                drive(($urandom_range(199) == 0), req, ($urandom_range(11) == 0));
            end
        end
        drive(0, 4'b0000, 0);
        drive(0, 4'b0000, 0);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
